// File: rtl/asip_pkg.sv
// Types and constants shared between the memory stage and the write-back stage.
// The beat struct mirrors one retired memory-stage transaction.
package asip_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    UPDATE = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] ptr;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] pa;
    logic              s_we;
    logic              v_we;
    logic              p_we;
  } wb_beat_t;

  function automatic logic beat_has_data(wb_beat_t b);
    return b.s_we | b.v_we;
  endfunction

  function automatic logic beat_writes(wb_beat_t b);
    return b.s_we | b.v_we | b.p_we;
  endfunction

endpackage

// File: rtl/writeback_stage.sv
// Write-back stage: turns retired beats into register-bank write pulses. A beat with both a
// data write and a pointer update takes two cycles because the scalar bank has one write port.
module writeback_stage
  import asip_pkg::*;
#(
  parameter int DATA_W = asip_pkg::DATA_W,
  parameter int ADDR_W = asip_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready depends
  // only on internal state, and in_valid may be held while in_ready is low.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_ptr,
  input  logic [ADDR_W-1:0] in_wa,
  input  logic [ADDR_W-1:0] in_pa,
  input  logic              in_s_we,
  input  logic              in_v_we,
  input  logic              in_p_we,
  output logic [DATA_W-1:0] wd3,
  output logic [ADDR_W-1:0] wa3,
  output logic [ADDR_W-1:0] r_update,
  output logic              reg_update,
  output logic              reg_s_write,
  output logic              reg_v_write,
  output logic [CNT_W-1:0]  retired,
  output logic [1:0]        dbg_state
);

  wb_beat_t          beat;
  wb_state_t         state_q, state_d;
  logic              ptr_pending_q;
  logic [DATA_W-1:0] pend_ptr_q;
  logic [ADDR_W-1:0] pend_pa_q;
  logic              accept;
  logic              drain;
  logic              beat_data;
  logic              beat_ptr;

  logic [DATA_W-1:0] wd3_d;
  logic [ADDR_W-1:0] wa3_d;
  logic [ADDR_W-1:0] r_update_d;
  logic              reg_update_d;
  logic              reg_s_write_d;
  logic              reg_v_write_d;

  assign beat = {in_result, in_ptr, in_wa, in_pa, in_s_we, in_v_we, in_p_we};
  assign beat_data = beat_has_data(beat);
  assign beat_ptr  = beat.p_we;

  // The only stall: the data half of a data+pointer beat is on the bus and the pointer must follow.
  assign drain     = (state_q == WRITE) && ptr_pending_q;
  assign in_ready  = !drain;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (drain) begin
      state_d = UPDATE;
    end else if (accept) begin
      if (beat_data) begin
        state_d = WRITE;
      end else if (beat_ptr) begin
        state_d = UPDATE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Next values of the registered bank-side outputs; data/address hold when nothing is written.
  always_comb begin
    wd3_d         = wd3;
    wa3_d         = wa3;
    r_update_d    = r_update;
    reg_update_d  = 1'b0;
    reg_s_write_d = 1'b0;
    reg_v_write_d = 1'b0;
    if (drain) begin
      wd3_d         = pend_ptr_q;
      r_update_d    = pend_pa_q;
      reg_update_d  = 1'b1;
      reg_s_write_d = 1'b1;
    end else if (accept && beat_data) begin
      wd3_d         = beat.result;
      wa3_d         = beat.wa;
      reg_s_write_d = beat.s_we;
      reg_v_write_d = beat.v_we;
    end else if (accept && beat_ptr) begin
      wd3_d         = beat.ptr;
      r_update_d    = beat.pa;
      reg_update_d  = 1'b1;
      reg_s_write_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd3         <= '0;
      wa3         <= '0;
      r_update    <= '0;
      reg_update  <= 1'b0;
      reg_s_write <= 1'b0;
      reg_v_write <= 1'b0;
    end else begin
      wd3         <= wd3_d;
      wa3         <= wa3_d;
      r_update    <= r_update_d;
      reg_update  <= reg_update_d;
      reg_s_write <= reg_s_write_d;
      reg_v_write <= reg_v_write_d;
    end
  end

  // Holding register for the pointer half of a data+pointer beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_pending_q <= 1'b0;
      pend_ptr_q    <= '0;
      pend_pa_q     <= '0;
    end else if (drain) begin
      ptr_pending_q <= 1'b0;
    end else if (accept) begin
      ptr_pending_q <= beat_data && beat_ptr;
      if (beat_data && beat_ptr) begin
        pend_ptr_q <= beat.ptr;
        pend_pa_q  <= beat.pa;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (accept && beat_writes(beat)) begin
      retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, reset and counter-wrap sequences, and
// random beats checked against a queue-of-pending-writes reference model.
module tb_writeback_stage;
  import asip_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int CW   = 4;
  localparam int OP_W = 3 + AW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic [DW-1:0] in_ptr;
  logic [AW-1:0] in_wa;
  logic [AW-1:0] in_pa;
  logic          in_s_we;
  logic          in_v_we;
  logic          in_p_we;
  logic [DW-1:0] wd3;
  logic [AW-1:0] wa3;
  logic [AW-1:0] r_update;
  logic          reg_update;
  logic          reg_s_write;
  logic          reg_v_write;
  logic [CW-1:0] retired;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_ptr(in_ptr), .in_wa(in_wa), .in_pa(in_pa),
    .in_s_we(in_s_we), .in_v_we(in_v_we), .in_p_we(in_p_we),
    .wd3(wd3), .wa3(wa3), .r_update(r_update), .reg_update(reg_update),
    .reg_s_write(reg_s_write), .reg_v_write(reg_v_write),
    .retired(retired), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: every accepted beat becomes a list of bank writes, one issued per cycle.
  // Each op is {is_ptr, s, v, addr, data}.
  logic [OP_W-1:0] exp_q[$];
  logic [DW-1:0]   m_wd;
  logic [AW-1:0]   m_wa, m_ru;
  logic            m_s, m_v, m_u, m_ready;
  int              m_ret;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wd = '0; m_wa = '0; m_ru = '0;
    m_s = 0; m_v = 0; m_u = 0; m_ready = 1; m_ret = 0;
  endtask

  task automatic model_step();
    logic [OP_W-1:0] op;
    if (in_valid && exp_q.size() == 0) begin
      if (in_s_we || in_v_we) exp_q.push_back({1'b0, in_s_we, in_v_we, in_wa, in_result});
      if (in_p_we) exp_q.push_back({1'b1, 1'b1, 1'b0, in_pa, in_ptr});
      if (in_s_we || in_v_we || in_p_we) m_ret = (m_ret + 1) % (1 << CW);
    end
    m_s = 0; m_v = 0; m_u = 0;
    if (exp_q.size() > 0) begin
      op = exp_q.pop_front();
      m_wd = op[DW-1:0];
      m_s  = op[OP_W-2];
      m_v  = op[OP_W-3];
      if (op[OP_W-1]) begin
        m_u  = 1;
        m_ru = op[DW+AW-1:DW];
      end else begin
        m_wa = op[DW+AW-1:DW];
      end
    end
    m_ready = (exp_q.size() == 0);
  endtask

  task automatic check_model(string tag);
    chk({tag, "_s"},   32'(reg_s_write), 32'(m_s));
    chk({tag, "_v"},   32'(reg_v_write), 32'(m_v));
    chk({tag, "_u"},   32'(reg_update),  32'(m_u));
    chk({tag, "_wd"},  wd3,              m_wd);
    chk({tag, "_wa"},  32'(wa3),         32'(m_wa));
    chk({tag, "_ru"},  32'(r_update),    32'(m_ru));
    chk({tag, "_rdy"}, 32'(in_ready),    32'(m_ready));
    chk({tag, "_ret"}, 32'(retired),     32'(m_ret));
  endtask

  task automatic drive(input logic v, input logic s, input logic vv, input logic p,
                       input logic [AW-1:0] wa, input logic [AW-1:0] pa,
                       input logic [DW-1:0] res, input logic [DW-1:0] ptr);
    in_valid = v; in_s_we = s; in_v_we = vv; in_p_we = p;
    in_wa = wa; in_pa = pa; in_result = res; in_ptr = ptr;
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, '0, '0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic v, s, vv, p;
    logic [AW-1:0] wa, pa;
    logic [DW-1:0] res, ptr;
    logic es, ev, eu;
    logic [DW-1:0] ewd;
    logic [AW-1:0] ewa, eru;
    logic erdy;
    logic [CW-1:0] eret;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1,1,0,0, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0,   1,0,0, 32'hDEADBEEF, 4'd3, 4'd0, 1, 4'd1};
    tbl[1] = '{0,0,0,0, 4'd0, 4'd0, 32'h0,        32'h0,   0,0,0, 32'hDEADBEEF, 4'd3, 4'd0, 1, 4'd1};
    tbl[2] = '{1,1,0,1, 4'd2, 4'd5, 32'h7,        32'h104, 1,0,0, 32'h7,        4'd2, 4'd0, 0, 4'd2};
    tbl[3] = '{1,1,0,1, 4'd2, 4'd5, 32'h7,        32'h104, 1,0,1, 32'h104,      4'd2, 4'd5, 1, 4'd2};
    tbl[4] = '{1,0,1,1, 4'd9, 4'd1, 32'h55,       32'h66,  0,1,0, 32'h55,       4'd9, 4'd5, 0, 4'd3};
    tbl[5] = '{0,0,0,0, 4'd0, 4'd0, 32'h0,        32'h0,   1,0,1, 32'h66,       4'd9, 4'd1, 1, 4'd3};
    tbl[6] = '{1,0,0,1, 4'd0, 4'd7, 32'h0,        32'hAA,  1,0,1, 32'hAA,       4'd9, 4'd7, 1, 4'd4};
    tbl[7] = '{1,0,0,0, 4'hF, 4'hF, 32'hFFFF,     32'hFFFF,0,0,0, 32'hAA,       4'd9, 4'd7, 1, 4'd4};
    tbl[8] = '{1,1,1,0, 4'd4, 4'd0, 32'h1234,     32'h0,   1,1,0, 32'h1234,     4'd4, 4'd7, 1, 4'd5};

    // Reset state.
    do_reset();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ret",   32'(retired),  32'd0);
    chk("rst_s",     32'(reg_s_write), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].vv, tbl[i].p, tbl[i].wa, tbl[i].pa, tbl[i].res, tbl[i].ptr);
      cycle($sformatf("tbl%0d_m", i));
      chk($sformatf("tbl%0d_s", i),   32'(reg_s_write), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_v", i),   32'(reg_v_write), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_u", i),   32'(reg_update),  32'(tbl[i].eu));
      chk($sformatf("tbl%0d_wd", i),  wd3,              tbl[i].ewd);
      chk($sformatf("tbl%0d_wa", i),  32'(wa3),         32'(tbl[i].ewa));
      chk($sformatf("tbl%0d_ru", i),  32'(r_update),    32'(tbl[i].eru));
      chk($sformatf("tbl%0d_rdy", i), 32'(in_ready),    32'(tbl[i].erdy));
      chk($sformatf("tbl%0d_ret", i), 32'(retired),     32'(tbl[i].eret));
    end
    drive(0, 0, 0, 0, '0, '0, '0, '0);
    cycle("tbl_tail");

    // Reset asserted while the pointer write is on the bus.
    drive(1, 1, 0, 1, 4'd6, 4'd6, 32'h11, 32'h22);
    cycle("rupd_w");
    drive(0, 0, 0, 0, '0, '0, '0, '0);
    cycle("rupd_u");
    chk("rupd_in_upd", 32'(reg_update), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rupd_s",   32'(reg_s_write), 32'd0);
    chk("rupd_u0",  32'(reg_update),  32'd0);
    chk("rupd_rdy", 32'(in_ready),    32'd1);
    chk("rupd_ret", 32'(retired),     32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle("rupd_after");

    // Reset with a pointer write still pending: it must never appear.
    drive(1, 1, 0, 1, 4'd2, 4'd8, 32'h33, 32'h44);
    cycle("rpend_w");
    chk("rpend_rdy0", 32'(in_ready), 32'd0);
    do_reset();
    cycle("rpend_a0");
    cycle("rpend_a1");
    chk("rpend_nos", 32'(reg_s_write), 32'd0);

    // Ten back-to-back vector beats.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, AW'($urandom_range(0, 15)), '0, $urandom, $urandom);
      cycle("b2b");
      chk("b2b_v",   32'(reg_v_write), 32'd1);
      chk("b2b_rdy", 32'(in_ready),    32'd1);
    end
    chk("b2b_ret", 32'(retired), 32'd10);
    drive(0, 0, 0, 0, '0, '0, '0, '0);
    cycle("b2b_tail");

    // Counter wrap: 17 writing beats and 3 bubbles leave a 4-bit count at 1.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 4 || i == 9 || i == 15)
        drive(1, 0, 0, 0, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom, $urandom);
      else if ($urandom_range(0, 1) == 1)
        drive(1, 1, 0, 0, AW'($urandom_range(0, 15)), '0, $urandom, '0);
      else
        drive(1, 0, 1, 0, AW'($urandom_range(0, 15)), '0, $urandom, '0);
      cycle("wrap");
    end
    chk("wrap_ret", 32'(retired), 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom),
            AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom, $urandom);
      cycle("rnd");
    end
    drive(0, 0, 0, 0, '0, '0, '0, '0);
    cycle("rnd_tail0");
    cycle("rnd_tail1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
